// File: rtl/de0_cv_pio_pkg.sv
// -----------------------------------------------------------------------------
// de0_cv_pio_pkg
// Shared definitions for the switch-PIO poll master:
//   - poll_state_e     : poll FSM states (IDLE, READ, WAIT_DATA, EVAL)
//   - PIO_DATA_ADDR    : Avalon word address of the PIO data register
//   - AVM_DATA_WIDTH   : Avalon-MM data bus width
//   - cnt_w()          : bits needed for a counter that must hold 0..max_val
// -----------------------------------------------------------------------------
package de0_cv_pio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ      = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_EVAL      = 2'd3
    } poll_state_e;

    localparam logic [1:0] PIO_DATA_ADDR  = 2'd0;
    localparam int         AVM_DATA_WIDTH = 32;

    // Width of a counter able to represent every value in 0..max_val (min 1 bit).
    function automatic int cnt_w(input int max_val);
        if (max_val < 2) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/de0_cv_switch_poll_master_if.sv
// -----------------------------------------------------------------------------
// de0_cv_switch_poll_master_if
// Avalon-MM read-only channel between the poll master and the switch PIO.
//   avm_address     : word address (master -> slave)
//   avm_read        : read request (master -> slave)
//   avm_waitrequest : slave stall (slave -> master)
//   avm_readdata    : registered read data (slave -> master)
// -----------------------------------------------------------------------------
interface de0_cv_switch_poll_master_if;
    import de0_cv_pio_pkg::*;

    logic [1:0]                avm_address;
    logic                      avm_read;
    logic                      avm_waitrequest;
    logic [AVM_DATA_WIDTH-1:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/de0_cv_pio_debounce.sv
// -----------------------------------------------------------------------------
// de0_cv_pio_debounce
// Debounce filter fed by one strobe per completed poll.
//   clk, reset       : clock, synchronous active-high reset
//   i_eval           : one-cycle strobe, i_sample is a fresh poll result
//   i_sample         : sampled switch word
//   o_stable_value   : last value seen STABLE_COUNT times in a row
//   o_changed        : one-cycle pulse on the cycle o_stable_value updates
//   o_sample_valid   : set once the first value has been accepted
// -----------------------------------------------------------------------------
module de0_cv_pio_debounce
    import de0_cv_pio_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int STABLE_COUNT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_eval,
    input  logic [DATA_WIDTH-1:0] i_sample,
    output logic [DATA_WIDTH-1:0] o_stable_value,
    output logic                  o_changed,
    output logic                  o_sample_valid
);

    localparam int              CNT_W   = cnt_w(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

    logic [DATA_WIDTH-1:0] r_candidate;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_stable;
    logic                  r_changed;
    logic                  r_sample_valid;

    logic                  w_same;
    logic [CNT_W-1:0]      w_next_count;
    logic                  w_reach;

    // Next match count: restart at 1 on a new value, saturate at STABLE_COUNT.
    always_comb begin
        w_same = (i_sample == r_candidate);
        if (!w_same) begin
            w_next_count = CNT_W'(1);
        end else if (r_count == CNT_MAX) begin
            w_next_count = r_count;
        end else begin
            w_next_count = r_count + CNT_W'(1);
        end
        w_reach = (w_next_count == CNT_MAX);
    end

    // Candidate/count/stable registers, updated only on the evaluate strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_candidate    <= '0;
            r_count        <= '0;
            r_stable       <= '0;
            r_changed      <= 1'b0;
            r_sample_valid <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (i_eval) begin
                // On a match the candidate already equals the sample, so one
                // assignment covers both branches.
                r_candidate <= i_sample;
                r_count     <= w_next_count;
                if (w_reach) begin
                    r_sample_valid <= 1'b1;
                    // An accepted value equal to the current word (including
                    // the reset value 0) validates without a change pulse.
                    if (i_sample != r_stable) begin
                        r_stable  <= i_sample;
                        r_changed <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_stable_value = r_stable;
    assign o_changed      = r_changed;
    assign o_sample_valid = r_sample_valid;

endmodule

// File: rtl/de0_cv_switch_poll_master.sv
// -----------------------------------------------------------------------------
// de0_cv_switch_poll_master
// Avalon-MM read initiator that polls the switch PIO data register every
// POLL_PERIOD clocks, debounces the result and publishes a stable word.
//   clk, reset    : clock, synchronous active-high reset
//   enable        : polling enable (an in-flight read always completes)
//   clear_err     : clears the sticky timeout flag
//   avm           : Avalon-MM master port (address, read, waitrequest, readdata)
//   stable_value  : debounced switch word
//   changed       : one-cycle pulse when stable_value updates
//   sample_valid  : high once the first stable value is accepted
//   timeout_err   : sticky flag, a read stalled TIMEOUT cycles and was aborted
// -----------------------------------------------------------------------------
module de0_cv_switch_poll_master
    import de0_cv_pio_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int POLL_PERIOD  = 50000,
    parameter int STABLE_COUNT = 8,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          clear_err,
    de0_cv_switch_poll_master_if.master   avm,
    output logic [DATA_WIDTH-1:0]         stable_value,
    output logic                          changed,
    output logic                          sample_valid,
    output logic                          timeout_err
);

    localparam int TMR_W = cnt_w(POLL_PERIOD - 1);
    localparam int STL_W = cnt_w(TIMEOUT);
    localparam int LAT_W = cnt_w(READ_LATENCY);

    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);
    localparam logic [STL_W-1:0] STALL_LAST = STL_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(READ_LATENCY - 1);

    poll_state_e           r_state;
    logic [TMR_W-1:0]      r_timer;
    logic [STL_W-1:0]      r_stall_cnt;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic                  r_avm_read;
    logic [DATA_WIDTH-1:0] r_sample;
    logic                  r_timeout_err;

    logic                  w_tick;
    logic                  w_accept;
    logic                  w_abort;
    logic                  w_capture;
    logic                  w_eval;

    // Decode of timer wrap, read acceptance/abort and data capture.
    always_comb begin
        w_tick    = enable && (r_timer == TMR_LAST);
        w_accept  = (r_state == ST_READ) && !avm.avm_waitrequest;
        // This stalled cycle is the TIMEOUT-th one.
        w_abort   = (r_state == ST_READ) && avm.avm_waitrequest &&
                    (r_stall_cnt == STALL_LAST);
        w_capture = (r_state == ST_WAIT_DATA) && (r_lat_cnt == LAT_LAST);
        w_eval    = (r_state == ST_EVAL);
    end

    // Free-running poll timer, parked at 0 while polling is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (!enable) begin
            r_timer <= '0;
        end else if (r_timer == TMR_LAST) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Poll FSM. A tick seen outside IDLE is simply not acted on.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_avm_read  <= 1'b0;
            r_stall_cnt <= '0;
            r_lat_cnt   <= '0;
            r_sample    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stall_cnt <= '0;
                    r_lat_cnt   <= '0;
                    if (w_tick) begin
                        r_state    <= ST_READ;
                        r_avm_read <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (w_accept) begin
                        r_state     <= ST_WAIT_DATA;
                        r_avm_read  <= 1'b0;
                        r_stall_cnt <= '0;
                    end else if (w_abort) begin
                        r_state     <= ST_IDLE;
                        r_avm_read  <= 1'b0;
                        r_stall_cnt <= '0;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + STL_W'(1);
                    end
                end
                ST_WAIT_DATA: begin
                    if (w_capture) begin
                        // Only the switch bits are kept; upper lanes are don't-care.
                        r_sample  <= avm.avm_readdata[DATA_WIDTH-1:0];
                        r_lat_cnt <= '0;
                        r_state   <= ST_EVAL;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                    end
                end
                ST_EVAL: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_avm_read <= 1'b0;
                end
            endcase
        end
    end

    // Sticky timeout flag; a new abort wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_abort) begin
            r_timeout_err <= 1'b1;
        end else if (clear_err) begin
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= r_timeout_err;
        end
    end

    de0_cv_pio_debounce #(
        .DATA_WIDTH   (DATA_WIDTH),
        .STABLE_COUNT (STABLE_COUNT)
    ) u_debounce (
        .clk            (clk),
        .reset          (reset),
        .i_eval         (w_eval),
        .i_sample       (r_sample),
        .o_stable_value (stable_value),
        .o_changed      (changed),
        .o_sample_valid (sample_valid)
    );

    assign avm.avm_address = PIO_DATA_ADDR;
    assign avm.avm_read    = r_avm_read;
    assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_de0_cv_switch_poll_master.sv
// -----------------------------------------------------------------------------
// tb_de0_cv_switch_poll_master
// Directed bench: a scripted Avalon slave answers reads from per-read stall and
// data tables; expected stable_value updates are queued when a scenario is set
// up and a monitor pops them whenever the DUT pulses changed.
// -----------------------------------------------------------------------------
module tb_de0_cv_switch_poll_master;
    import de0_cv_pio_pkg::*;

    localparam int DW = 10;
    localparam logic [21:0] HI_JUNK = 22'h2A5A5A;
    localparam logic [31:0] JUNK    = 32'hA5A5_A03C;

    typedef struct {
        logic [DW-1:0] value;
        int            read_idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          clear_err = 1'b0;
    logic [DW-1:0] stable_value;
    logic          changed;
    logic          sample_valid;
    logic          timeout_err;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    exp_t          exp_q[$];
    int            stall_q[$];
    logic [DW-1:0] data_q[$];
    int            launch_q[$];
    logic [DW-1:0] dflt_val = '0;
    int            acc_count = 0;
    int            acc_cyc = 0;
    int            rd_cycles = 0;
    int            rd_launches = 0;

    de0_cv_switch_poll_master_if bus();

    de0_cv_switch_poll_master #(
        .DATA_WIDTH   (DW),
        .POLL_PERIOD  (4),
        .STABLE_COUNT (3),
        .READ_LATENCY (1),
        .TIMEOUT      (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear_err    (clear_err),
        .avm          (bus),
        .stable_value (stable_value),
        .changed      (changed),
        .sample_valid (sample_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_acc(input int n, input int bound, input string name);
        int k = 0;
        while (acc_count < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (acc_count < n) timeout_fail(name);
    endtask

    task automatic wait_exp_empty(input int bound, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) timeout_fail(name);
    endtask

    task automatic clear_tb_state();
        stall_q.delete();
        data_q.delete();
        exp_q.delete();
        launch_q.delete();
        dflt_val    = '0;
        acc_count   = 0;
        rd_cycles   = 0;
        rd_launches = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        clear_err = 1'b0;
        wait_cycles(2);
        clear_tb_state();
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_avm_read"},     {31'd0, bus.avm_read},     32'd0);
        chk({tag, "_avm_address"},  {30'd0, bus.avm_address},  32'd0);
        chk({tag, "_stable_value"}, {22'd0, stable_value},     32'd0);
        chk({tag, "_changed"},      {31'd0, changed},          32'd0);
        chk({tag, "_sample_valid"}, {31'd0, sample_valid},     32'd0);
        chk({tag, "_timeout_err"},  {31'd0, timeout_err},      32'd0);
    endtask

    // Scripted Avalon slave, acting 1 time unit after each rising edge.
    initial begin
        bit            in_read = 1'b0;
        bit            pend = 1'b0;
        bit            junk = 1'b0;
        int            stall_left = 0;
        logic [DW-1:0] val = '0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = JUNK;
        forever begin
            @(posedge clk);
            #1;
            if (junk) begin
                bus.avm_readdata = JUNK;
                junk = 1'b0;
            end
            if (pend) begin
                bus.avm_readdata = {HI_JUNK, val};
                pend = 1'b0;
                junk = 1'b1;
            end
            if (reset) begin
                in_read = 1'b0;
                pend    = 1'b0;
                bus.avm_waitrequest = 1'b0;
            end else if (bus.avm_read) begin
                if (!in_read) begin
                    in_read = 1'b1;
                    if (stall_q.size() > 0) stall_left = stall_q.pop_front();
                    else stall_left = 0;
                end
                if (stall_left > 0) begin
                    bus.avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    in_read = 1'b0;
                    if (data_q.size() > 0) val = data_q.pop_front();
                    else val = dflt_val;
                    pend = 1'b1;
                    acc_count++;
                    acc_cyc = cyc;
                end
            end else begin
                bus.avm_waitrequest = 1'b0;
                in_read = 1'b0;
            end
        end
    end

    // Monitor: read activity bookkeeping and scoreboard check on each change pulse.
    initial begin
        bit   prev_read = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.avm_read) begin
                rd_cycles++;
                chk("avm_address_during_read", {30'd0, bus.avm_address}, 32'd0);
                if (!prev_read) begin
                    rd_launches++;
                    launch_q.push_back(cyc);
                end
            end
            prev_read = bus.avm_read;
            if (changed) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL changed_unexpected: stable_value %0h at cycle %0d, none expected",
                             stable_value, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("stable_value", {22'd0, stable_value}, {22'd0, e.value});
                    chk("change_read_idx", acc_count, e.read_idx);
                    chk("accept_to_changed", cyc - acc_cyc, 32'd3);
                    chk("sample_valid_on_change", {31'd0, sample_valid}, 32'd1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;

        // Reset state and idle while disabled.
        wait_cycles(3);
        chk_reset_outputs("reset");
        clear_tb_state();
        reset = 1'b0;
        wait_cycles(8);
        chk("no_poll_when_disabled", rd_launches, 32'd0);

        // Constant 0x155: accepted on the third poll; timer and poll spacing.
        dflt_val = 10'h155;
        exp_q.push_back('{10'h155, 3});
        c0 = cyc;
        enable = 1'b1;
        wait_exp_empty(60, "first_stable");
        wait_cycles(16);
        chk("t1_sample_valid", {31'd0, sample_valid}, 32'd1);
        if (launch_q.size() >= 3) begin
            chk("enable_to_first_read", launch_q[0] - c0, 32'd4);
            chk("poll_spacing_1", launch_q[1] - launch_q[0], 32'd4);
            chk("poll_spacing_2", launch_q[2] - launch_q[1], 32'd4);
        end else begin
            timeout_fail("poll_launches");
        end

        // Glitch rejection and successive changes, including a change back to 0.
        do_reset();
        data_q = '{10'h155, 10'h0AA, 10'h155, 10'h155, 10'h155,
                   10'h0AA, 10'h0AA, 10'h0AA, 10'h000, 10'h000, 10'h000};
        exp_q.push_back('{10'h155, 5});
        exp_q.push_back('{10'h0AA, 8});
        exp_q.push_back('{10'h000, 11});
        enable = 1'b1;
        wait_exp_empty(150, "sequence_changes");
        wait_cycles(8);
        chk("t2_stable_value", {22'd0, stable_value}, 32'd0);
        chk("t2_sample_valid", {31'd0, sample_valid}, 32'd1);

        // First accepted value 0: sample_valid without a change pulse.
        do_reset();
        enable = 1'b1;
        wait_acc(2, 40, "zero_acc2");
        wait_cycles(3);
        chk("zero_not_yet_valid", {31'd0, sample_valid}, 32'd0);
        wait_acc(3, 40, "zero_acc3");
        wait_cycles(3);
        chk("zero_valid", {31'd0, sample_valid}, 32'd1);
        chk("zero_stable", {22'd0, stable_value}, 32'd0);

        // Three stalled cycles: read held four cycles, no timeout.
        do_reset();
        stall_q.push_back(3);
        dflt_val = 10'h155;
        exp_q.push_back('{10'h155, 3});
        enable = 1'b1;
        wait_acc(1, 40, "stall3_accept");
        wait_cycles(1);
        chk("stall3_read_cycles", rd_cycles, 32'd4);
        chk("stall3_timeout_err", {31'd0, timeout_err}, 32'd0);
        wait_exp_empty(80, "stall3_stable");
        chk("stall3_timeout_err_end", {31'd0, timeout_err}, 32'd0);

        // Five stalled cycles: abort, sticky flag, clear.
        do_reset();
        stall_q.push_back(5);
        dflt_val = 10'h155;
        enable = 1'b1;
        begin
            int k = 0;
            while (!timeout_err && k < 40) begin
                @(negedge clk);
                k++;
            end
            if (!timeout_err) timeout_fail("timeout_set");
        end
        enable = 1'b0;
        chk("timeout_read_dropped", {31'd0, bus.avm_read}, 32'd0);
        chk("timeout_read_cycles", rd_cycles, 32'd5);
        chk("timeout_no_accept", acc_count, 32'd0);
        chk("timeout_stable", {22'd0, stable_value}, 32'd0);
        wait_cycles(4);
        chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("timeout_cleared", {31'd0, timeout_err}, 32'd0);
        wait_cycles(4);
        chk("timeout_launches", rd_launches, 32'd1);

        // enable dropped while the read is stalled: it still completes.
        do_reset();
        stall_q.push_back(2);
        dflt_val = 10'h155;
        enable = 1'b1;
        begin
            int k = 0;
            while (!bus.avm_read && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!bus.avm_read) timeout_fail("en_drop_read_start");
        end
        enable = 1'b0;
        wait_cycles(20);
        chk("en_drop_accepts", acc_count, 32'd1);
        chk("en_drop_read_cycles", rd_cycles, 32'd3);
        chk("en_drop_launches", rd_launches, 32'd1);
        chk("en_drop_timeout_err", {31'd0, timeout_err}, 32'd0);

        // Reset during WAIT_DATA of the third poll: nothing reaches stable_value.
        do_reset();
        dflt_val = 10'h155;
        enable = 1'b1;
        wait_acc(3, 60, "rst_wait_acc3");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_wait");
        clear_tb_state();
        dflt_val = 10'h155;
        exp_q.push_back('{10'h155, 3});
        reset = 1'b0;
        wait_exp_empty(60, "rst_wait_restart");
        chk("rst_wait_sample_valid", {31'd0, sample_valid}, 32'd1);
        enable = 1'b0;
        wait_cycles(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
